// File: rtl/ysyx_22050612_ifu.sv
// ysyx_22050612_ifu: instruction fetch unit for the single-issue RV64 core.
// Owns the PC, fetches one aligned doubleword per instruction, extracts the
// 32-bit instruction, hands it to decode and waits for execute to commit the
// next PC. One instruction is in flight at a time.
// Optional feature macro: YSYX_22050612_IFU_PERF_EN (fetch/stall perf counters).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | just out of reset, outputs quiet, checks RESET_PC alignment
// S_REQ   | fetch request presented, address held until accepted
// S_WAIT  | request accepted, waiting for the response doubleword
// S_HOLD  | instruction offered to decode, held until taken
// S_EXEC  | decode took it, waiting for execute to commit dnpc
// S_FAULT | misaligned PC seen, fetch stopped until reset
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [63:0] mem_resp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_pc_o,
    input  logic        commit_valid_i,
    input  logic [63:0] commit_dnpc_i,
    output logic        fault_o,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_stall_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [63:0] inst_pc_q, inst_pc_d;

    // State and datapath registers; reset returns to IDLE at RESET_PC with cleared outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Next-state logic and capture of the instruction / committed PC.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = (pc_q[1:0] != 2'b00) ? S_FAULT : S_REQ;
            end
            S_REQ: begin
                if (mem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    // pc[2] selects which word of the aligned doubleword holds the instruction.
                    inst_d    = pc_q[2] ? mem_resp_data_i[63:32] : mem_resp_data_i[31:0];
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready_i) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (commit_valid_i) begin
                    pc_d    = commit_dnpc_i;
                    state_d = (commit_dnpc_i[1:0] != 2'b00) ? S_FAULT : S_REQ;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode the registered state only, so no input reaches them combinationally.
    assign mem_req_valid_o = (state_q == S_REQ);
    assign mem_req_addr_o  = (state_q == S_REQ) ? {pc_q[63:3], 3'b000} : 64'd0;
    assign inst_valid_o    = (state_q == S_HOLD);
    assign fault_o         = (state_q == S_FAULT);
    assign inst_o          = inst_q;
    assign inst_pc_o       = inst_pc_q;

`ifdef YSYX_22050612_IFU_PERF_EN
    logic [63:0] fetch_cnt_q, fetch_cnt_d;
    logic [63:0] stall_cnt_q, stall_cnt_d;

    // Fetch count bumps on the decode handshake; stall count on every REQ/WAIT cycle.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_HOLD) && inst_ready_i) fetch_cnt_d = fetch_cnt_q + 64'd1;
        if ((state_q == S_REQ) || (state_q == S_WAIT)) stall_cnt_d = stall_cnt_q + 64'd1;
    end

    // Perf counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_fetch_cnt_o = 64'd0;
    assign perf_stall_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed testbench for ysyx_22050612_ifu. Inputs change and outputs are
// sampled 1 time unit after each rising edge. Perf counter expectations
// follow YSYX_22050612_IFU_PERF_EN (zero when the macro is undefined).
module tb_ysyx_22050612_ifu;

`ifdef YSYX_22050612_IFU_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        commit_valid;
    logic [63:0] commit_dnpc;
    logic        fault;
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ysyx_22050612_ifu dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .mem_req_valid_o  (mem_req_valid),
        .mem_req_ready_i  (mem_req_ready),
        .mem_req_addr_o   (mem_req_addr),
        .mem_resp_valid_i (mem_resp_valid),
        .mem_resp_data_i  (mem_resp_data),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .commit_valid_i   (commit_valid),
        .commit_dnpc_i    (commit_dnpc),
        .fault_o          (fault),
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pexp(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, ".req_valid"},  {63'd0, mem_req_valid}, 64'd0);
        check({tag, ".req_addr"},   mem_req_addr, 64'd0);
        check({tag, ".inst_valid"}, {63'd0, inst_valid}, 64'd0);
        check({tag, ".inst"},       {32'd0, inst}, 64'd0);
        check({tag, ".inst_pc"},    inst_pc, 64'd0);
        check({tag, ".fault"},      {63'd0, fault}, 64'd0);
        check({tag, ".fetch_cnt"},  perf_fetch_cnt, 64'd0);
        check({tag, ".stall_cnt"},  perf_stall_cnt, 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 64'd0;
        inst_ready     = 1'b0;
        commit_valid   = 1'b0;
        commit_dnpc    = 64'd0;

        // Reset state
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;                       // cycle 0: IDLE
        check_quiet("cycle0");

        // First fetch: request at cycle 1, response at cycle 2, valid at cycle 3
        tick();
        check("f1.req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("f1.req_addr",  mem_req_addr, 64'h8000_0000);
        tick();
        check("f1.wait_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("f1.wait_addr",      mem_req_addr, 64'd0);
        check("f1.wait_inst_valid", {63'd0, inst_valid}, 64'd0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0010_0093_0000_0013;
        tick();
        mem_resp_valid = 1'b0;
        check("f1.inst_valid", {63'd0, inst_valid}, 64'd1);
        check("f1.inst",       {32'd0, inst}, 64'h0000_0013);
        check("f1.inst_pc",    inst_pc, 64'h8000_0000);
        check("f1.stall_cnt",  perf_stall_cnt, pexp(64'd2));
        check("f1.fetch_cnt_hold", perf_fetch_cnt, 64'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("f1.exec_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("f1.fetch_cnt", perf_fetch_cnt, pexp(64'd1));

        // Second fetch from the upper half of the same doubleword
        commit_valid = 1'b1;
        commit_dnpc  = 64'h8000_0004;
        tick();
        commit_valid = 1'b0;
        check("f2.req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("f2.req_addr",  mem_req_addr, 64'h8000_0000);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h0010_0093_0000_0013;
        tick();
        mem_resp_valid = 1'b0;
        check("f2.inst",    {32'd0, inst}, 64'h0010_0093);
        check("f2.inst_pc", inst_pc, 64'h8000_0004);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("f2.fetch_cnt", perf_fetch_cnt, pexp(64'd2));
        check("f2.stall_cnt", perf_stall_cnt, pexp(64'd4));

        // Third fetch: ready low 3 cycles, response 4 cycles after accept
        commit_valid  = 1'b1;
        commit_dnpc   = 64'h8000_0008;
        mem_req_ready = 1'b0;
        tick();
        commit_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("f3.stall_req_valid", {63'd0, mem_req_valid}, 64'd1);
            check("f3.stall_addr",      mem_req_addr, 64'h8000_0008);
            tick();
        end
        mem_req_ready = 1'b1;
        check("f3.accept_addr", mem_req_addr, 64'h8000_0008);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("f3.wait_req_valid",  {63'd0, mem_req_valid}, 64'd0);
            check("f3.wait_inst_valid", {63'd0, inst_valid}, 64'd0);
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD_BEEF_00A0_0513;
        tick();
        check("f3.inst_valid", {63'd0, inst_valid}, 64'd1);
        check("f3.inst",       {32'd0, inst}, 64'h00A0_0513);
        check("f3.inst_pc",    inst_pc, 64'h8000_0008);
        check("f3.stall_cnt",  perf_stall_cnt, pexp(64'd12));

        // Spurious response in HOLD, then inst_ready low 5 cycles with a stray commit
        mem_resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        check("hold.spurious_inst", {32'd0, inst}, 64'h00A0_0513);
        for (int i = 0; i < 5; i++) begin
            commit_valid = (i == 2);
            commit_dnpc  = 64'h8000_0200;
            check("hold.inst_valid", {63'd0, inst_valid}, 64'd1);
            check("hold.inst",       {32'd0, inst}, 64'h00A0_0513);
            check("hold.inst_pc",    inst_pc, 64'h8000_0008);
            check("hold.req_valid",  {63'd0, mem_req_valid}, 64'd0);
            tick();
        end
        commit_valid = 1'b0;
        inst_ready   = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("exec.inst_valid", {63'd0, inst_valid}, 64'd0);
        check("exec.fetch_cnt",  perf_fetch_cnt, pexp(64'd3));
        tick();
        check("exec.no_req", {63'd0, mem_req_valid}, 64'd0);

        // Misaligned dnpc -> sticky fault
        commit_valid = 1'b1;
        commit_dnpc  = 64'h8000_0102;
        tick();
        commit_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_resp_valid = 1'b1;
            commit_valid   = 1'b1;
            commit_dnpc    = 64'h8000_0000;
            check("fault.fault",      {63'd0, fault}, 64'd1);
            check("fault.req_valid",  {63'd0, mem_req_valid}, 64'd0);
            check("fault.inst_valid", {63'd0, inst_valid}, 64'd0);
            tick();
        end
        mem_resp_valid = 1'b0;
        commit_valid   = 1'b0;
        rst = 1'b1;
        tick();
        check_quiet("fault_rst");
        rst = 1'b0;
        tick();
        check("restart.req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("restart.req_addr",  mem_req_addr, 64'h8000_0000);
        tick();                           // now in WAIT

        // Reset in WAIT; late response during IDLE must be ignored
        rst = 1'b1;
        tick();
        check_quiet("wait_rst");
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'h1111_1111_2222_2222;
        tick();
        mem_resp_valid = 1'b0;
        check("late.inst",       {32'd0, inst}, 64'd0);
        check("late.inst_valid", {63'd0, inst_valid}, 64'd0);
        check("late.req_valid",  {63'd0, mem_req_valid}, 64'd1);
        check("late.req_addr",   mem_req_addr, 64'h8000_0000);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hCAFE_BABE_0000_0013;
        tick();
        mem_resp_valid = 1'b0;
        check("clean.inst_valid", {63'd0, inst_valid}, 64'd1);
        check("clean.inst",       {32'd0, inst}, 64'h0000_0013);
        check("clean.inst_pc",    inst_pc, 64'h8000_0000);
        check("clean.stall_cnt",  perf_stall_cnt, pexp(64'd2));
        check("clean.fetch_cnt",  perf_fetch_cnt, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifu.md
# ysyx_22050612_IFU

Instruction fetch unit for the single-issue RV64 core, directly upstream of the decode/execute stage. Owns the architectural PC, issues one 64-bit-aligned read per instruction to instruction memory over a valid/ready request plus response-valid channel, and extracts the 32-bit instruction from the returned doubleword. Presents `{inst, pc}` to decode with a valid/ready handshake, then waits for execute to commit `dnpc` before fetching again; one instruction is in flight at a time.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded on reset.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `mem_req_valid` out 1: fetch request valid.
- `mem_req_ready` in 1: memory accepts request this cycle.
- `mem_req_addr` out 64: `{pc[63:3], 3'b000}`.
- `mem_resp_valid` in 1: response data valid; earliest one cycle after acceptance.
- `mem_resp_data` in 64: fetched doubleword.
- `inst_valid` out 1: `inst`/`inst_pc` valid to decode.
- `inst_ready` in 1: decode takes the instruction.
- `inst` out 32: fetched instruction.
- `inst_pc` out 64: PC of `inst`.
- `commit_valid` in 1: execute finished the instruction; `commit_dnpc` valid.
- `commit_dnpc` in 64: next PC from execute.
- `fault` out 1: sticky misaligned-fetch flag.
- `perf_fetch_cnt` out 64: instructions delivered to decode.
- `perf_stall_cnt` out 64: cycles spent in REQ or WAIT.

## Operation
- States: IDLE, REQ, WAIT, HOLD, EXEC, FAULT.
- IDLE: entered on reset; all outputs 0; next cycle -> REQ, or FAULT if `pc[1:0]!=0`.
- REQ: `mem_req_valid=1`; on `mem_req_ready` -> WAIT; otherwise stay, address stable.
- WAIT: on `mem_resp_valid`, register `inst = pc[2] ? data[63:32] : data[31:0]`, `inst_pc = pc` -> HOLD.
- HOLD: `inst_valid=1`, `inst`/`inst_pc` held stable; on `inst_ready` -> EXEC.
- EXEC: on `commit_valid`, `pc <= commit_dnpc`; if `commit_dnpc[1:0]!=0` -> FAULT, else -> REQ.
- FAULT: `fault=1`, no requests, `inst_valid=0`; left only by `rst`.
- PC width is 64 bits; the IFU performs no PC arithmetic; no wrap handling needed.
- Ignored inputs: `mem_resp_valid` outside WAIT; `commit_valid` outside EXEC; `inst_ready` outside HOLD.
- `rst` in any state, including mid-request or WAIT, forces IDLE, `pc=RESET_PC`, and clears `inst`, `inst_pc`, `fault`, and counters. The memory model shares `rst` and drops outstanding responses.

## Timing
- Reset values: `mem_req_valid=0`, `mem_req_addr=0`, `inst_valid=0`, `inst=0`, `inst_pc=0`, `fault=0`, counters 0.
- `mem_req_addr` is driven only in REQ; it is 0 elsewhere.
- Minimum loop: commit at cycle t -> REQ at t+1 -> accept at t+1 -> WAIT at t+2 -> response at t+2 -> `inst_valid` at t+3.
- First `inst_valid` after reset release at cycle 0 is at the earliest cycle 3.
- `inst_valid` and `mem_req_valid` are registered state decodes; no combinational path from any input to them.
- `perf_fetch_cnt` increments in the cycle after the HOLD handshake.
- `perf_stall_cnt` increments every cycle the state is REQ or WAIT.

## Configuration
- `YSYX_22050612_IFU_PERF_EN`: when defined, both perf counters are implemented as described.
- When undefined, no counter flops exist; `perf_fetch_cnt` and `perf_stall_cnt` are tied to 0; all other behaviour is identical.

## Test plan
- Reset with a ready memory that responds 1 cycle after accept; mem holds 0x00100093_00000013 at 0x80000000 -> addr 0x80000000 issued at cycle 1; `inst=0x00000013`, `inst_pc=0x80000000`, `inst_valid=1` at cycle 3.
- Commit `dnpc=0x80000004` -> addr 0x80000000 again; `inst=0x00100093` (upper half); `perf_fetch_cnt=2`.
- `mem_req_ready` low 3 cycles and response delayed 4 cycles -> address stable throughout; `perf_stall_cnt` increases by 3+4+1; a spurious `mem_resp_valid` in HOLD has no effect.
- `inst_ready` low 5 cycles in HOLD -> `inst`/`inst_pc` unchanged; `commit_valid` pulsed meanwhile is ignored; no new request issued.
- Commit `dnpc=0x80000102` -> FAULT: `fault=1` sticky, `mem_req_valid=0` indefinitely; `rst` -> `fault=0`, fetch restarts at 0x80000000.
- Assert `rst` while in WAIT -> IDLE next cycle, all outputs 0; the late response is ignored; a clean fetch at `RESET_PC` follows.
